// File: rtl/mips_multi_control.sv
// Multicycle MIPS control FSM: decodes Op/Funct into datapath controls.
// Optional jump support is enabled by defining MIPS_CTRL_JUMP_EN.
module mips_multi_control #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       Op,
    input  logic [5:0]       Funct,
    output logic             PC_write,
    output logic             Mem_write,
    output logic             lorD_mux,
    output logic             IR_write,
    output logic             Reg_Dst_mux,
    output logic             Mem_reg_mux,
    output logic             Reg_write,
    output logic             ALU_srcA_mux,
    output logic [1:0]       ALU_srcB_mux,
    output logic [2:0]       ALU_control,
    output logic [1:0]       Pc_src_mux,
    output logic             Branch,
    output logic             instr_done_o,
    output logic             illegal_o,
    output logic [CNT_W-1:0] instr_count_o,
    output logic [3:0]       state_o
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTE  = 4'd6,
        ALUWB    = 4'd7,
        BRANCH   = 4'd8,
        ADDIEX   = 4'd9,
        ADDIWB   = 4'd10,
        JUMP     = 4'd11
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
`ifdef MIPS_CTRL_JUMP_EN
    localparam logic [5:0] OP_J    = 6'b000010;
`endif

    state_t           state;
    state_t           dec;
    logic [CNT_W-1:0] count;
    logic             op_ok;

    logic pc_write_d, mem_write_d, ir_write_d, reg_write_d;
    logic branch_d, done_d, illegal_d, pc_src_lo;
`ifdef MIPS_CTRL_JUMP_EN
    logic pc_src_hi;
`endif

    // During reset the output decode shows FETCH regardless of the state register.
    assign dec     = rst_n ? state : FETCH;
    assign state_o = state;
    assign instr_count_o = count;

    // Opcode legality seen from DECODE.
    always_comb begin
        op_ok = 1'b0;
        case (Op)
            OP_LW, OP_SW, OP_R, OP_BEQ, OP_ADDI: op_ok = 1'b1;
`ifdef MIPS_CTRL_JUMP_EN
            OP_J: op_ok = 1'b1;
`endif
            default: op_ok = 1'b0;
        endcase
    end

    // Moore output decode; only EXECUTE and DECODE look at the IR fields.
    always_comb begin
        pc_write_d   = 1'b0;
        mem_write_d  = 1'b0;
        ir_write_d   = 1'b0;
        reg_write_d  = 1'b0;
        branch_d     = 1'b0;
        done_d       = 1'b0;
        illegal_d    = 1'b0;
        pc_src_lo    = 1'b0;
`ifdef MIPS_CTRL_JUMP_EN
        pc_src_hi    = 1'b0;
`endif
        lorD_mux     = 1'b0;
        Reg_Dst_mux  = 1'b0;
        Mem_reg_mux  = 1'b0;
        ALU_srcA_mux = 1'b0;
        ALU_srcB_mux = 2'b00;
        ALU_control  = 3'b000;
        unique case (dec)
            FETCH: begin
                ir_write_d   = 1'b1;
                pc_write_d   = 1'b1;
                ALU_srcB_mux = 2'b01;
                ALU_control  = 3'b010;
            end
            DECODE: begin
                ALU_srcB_mux = 2'b11;
                ALU_control  = 3'b010;
                illegal_d    = ~op_ok;
                done_d       = ~op_ok;
            end
            MEMADR, ADDIEX: begin
                ALU_srcA_mux = 1'b1;
                ALU_srcB_mux = 2'b10;
                ALU_control  = 3'b010;
            end
            MEMREAD: lorD_mux = 1'b1;
            MEMWB: begin
                reg_write_d = 1'b1;
                Mem_reg_mux = 1'b1;
                done_d      = 1'b1;
            end
            MEMWRITE: begin
                lorD_mux    = 1'b1;
                mem_write_d = 1'b1;
                done_d      = 1'b1;
            end
            EXECUTE: begin
                ALU_srcA_mux = 1'b1;
                case (Funct)
                    6'b100000: ALU_control = 3'b010;
                    6'b100010: ALU_control = 3'b110;
                    6'b100100: ALU_control = 3'b000;
                    6'b100101: ALU_control = 3'b001;
                    6'b101010: ALU_control = 3'b111;
                    default: begin
                        ALU_control = 3'b010;
                        illegal_d   = 1'b1;
                    end
                endcase
            end
            ALUWB: begin
                reg_write_d = 1'b1;
                Reg_Dst_mux = 1'b1;
                done_d      = 1'b1;
            end
            BRANCH: begin
                ALU_srcA_mux = 1'b1;
                ALU_control  = 3'b110;
                pc_src_lo    = 1'b1;
                branch_d     = 1'b1;
                done_d       = 1'b1;
            end
            ADDIWB: begin
                reg_write_d = 1'b1;
                done_d      = 1'b1;
            end
`ifdef MIPS_CTRL_JUMP_EN
            JUMP: begin
                pc_write_d = 1'b1;
                pc_src_hi  = 1'b1;
                done_d     = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    assign PC_write     = rst_n & pc_write_d;
    assign Mem_write    = rst_n & mem_write_d;
    assign IR_write     = rst_n & ir_write_d;
    assign Reg_write    = rst_n & reg_write_d;
    assign Branch       = rst_n & branch_d;
    assign instr_done_o = rst_n & done_d;
    assign illegal_o    = rst_n & illegal_d;
`ifdef MIPS_CTRL_JUMP_EN
    assign Pc_src_mux   = {pc_src_hi, pc_src_lo};
`else
    assign Pc_src_mux   = {1'b0, pc_src_lo};
`endif

    // State sequencing and retired-instruction counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= FETCH;
            count <= '0;
        end else begin
            if (instr_done_o) count <= count + CNT_W'(1);
            case (state)
                FETCH: state <= DECODE;
                DECODE: begin
                    case (Op)
                        OP_LW, OP_SW: state <= MEMADR;
                        OP_R:         state <= EXECUTE;
                        OP_BEQ:       state <= BRANCH;
                        OP_ADDI:      state <= ADDIEX;
`ifdef MIPS_CTRL_JUMP_EN
                        OP_J:         state <= JUMP;
`endif
                        default:      state <= FETCH;
                    endcase
                end
                MEMADR:  state <= (Op == OP_SW) ? MEMWRITE : MEMREAD;
                MEMREAD: state <= MEMWB;
                EXECUTE: state <= ALUWB;
                ADDIEX:  state <= ADDIWB;
                default: state <= FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_multi_control.sv
// Self-checking bench for mips_multi_control: directed table, corner
// sequences and randomized instruction streams against a sequence model.
module tb_mips_multi_control;

    localparam int CW = 8;
`ifdef MIPS_CTRL_JUMP_EN
    localparam bit JEN = 1'b1;
`else
    localparam bit JEN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [5:0]    Op = '0;
    logic [5:0]    Funct = '0;
    logic          PC_write, Mem_write, lorD_mux, IR_write;
    logic          Reg_Dst_mux, Mem_reg_mux, Reg_write, ALU_srcA_mux;
    logic [1:0]    ALU_srcB_mux;
    logic [2:0]    ALU_control;
    logic [1:0]    Pc_src_mux;
    logic          Branch, instr_done_o, illegal_o;
    logic [CW-1:0] instr_count_o;
    logic [3:0]    state_o;

    always #5 clk = ~clk;

    mips_multi_control #(.CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .Op(Op), .Funct(Funct),
        .PC_write(PC_write), .Mem_write(Mem_write),
        .lorD_mux(lorD_mux), .IR_write(IR_write),
        .Reg_Dst_mux(Reg_Dst_mux), .Mem_reg_mux(Mem_reg_mux),
        .Reg_write(Reg_write), .ALU_srcA_mux(ALU_srcA_mux),
        .ALU_srcB_mux(ALU_srcB_mux), .ALU_control(ALU_control),
        .Pc_src_mux(Pc_src_mux), .Branch(Branch),
        .instr_done_o(instr_done_o), .illegal_o(illegal_o),
        .instr_count_o(instr_count_o), .state_o(state_o)
    );

    typedef struct packed {
        logic       pcw, memw, iord, irw, regdst, memreg, regw, srca;
        logic [1:0] srcb;
        logic [2:0] alu;
        logic [1:0] pcsrc;
        logic       branch, done, ill;
    } ctl_t;

    ctl_t act;
    assign act = {PC_write, Mem_write, lorD_mux, IR_write, Reg_Dst_mux,
                  Mem_reg_mux, Reg_write, ALU_srcA_mux, ALU_srcB_mux,
                  ALU_control, Pc_src_mux, Branch, instr_done_o, illegal_o};

    int errs = 0;
    int checks = 0;
    logic [CW-1:0] exp_cnt = '0;

    function automatic bit legal_op(logic [5:0] op);
        return (op == 6'h23) || (op == 6'h2B) || (op == 6'h00) ||
               (op == 6'h04) || (op == 6'h08) || (JEN && op == 6'h02);
    endfunction

    // Control values the specification lists for each step of an instruction.
    function automatic ctl_t model(int st, logic [5:0] op, logic [5:0] fn);
        ctl_t c = '0;
        case (st)
            0:  begin c.irw = 1; c.pcw = 1; c.srcb = 2'b01; c.alu = 3'b010; end
            1:  begin
                c.srcb = 2'b11; c.alu = 3'b010;
                if (!legal_op(op)) begin c.ill = 1; c.done = 1; end
            end
            2, 9: begin c.srca = 1; c.srcb = 2'b10; c.alu = 3'b010; end
            3:  c.iord = 1;
            4:  begin c.regw = 1; c.memreg = 1; c.done = 1; end
            5:  begin c.iord = 1; c.memw = 1; c.done = 1; end
            6:  begin
                c.srca = 1;
                if (fn == 6'h20) c.alu = 3'b010;
                else if (fn == 6'h22) c.alu = 3'b110;
                else if (fn == 6'h24) c.alu = 3'b000;
                else if (fn == 6'h25) c.alu = 3'b001;
                else if (fn == 6'h2A) c.alu = 3'b111;
                else begin c.alu = 3'b010; c.ill = 1; end
            end
            7:  begin c.regw = 1; c.regdst = 1; c.done = 1; end
            8:  begin
                c.srca = 1; c.alu = 3'b110; c.pcsrc = 2'b01;
                c.branch = 1; c.done = 1;
            end
            10: begin c.regw = 1; c.done = 1; end
            11: begin c.pcw = 1; c.pcsrc = 2'b10; c.done = 1; end
            default: c = '0;
        endcase
        return c;
    endfunction

    function automatic ctl_t gated(ctl_t c);
        ctl_t g = c;
        g.pcw = 0; g.memw = 0; g.irw = 0; g.regw = 0;
        g.branch = 0; g.done = 0; g.ill = 0;
        return g;
    endfunction

    // The state walk an instruction takes, by instruction class.
    task automatic get_seq(input logic [5:0] op, output int s[6], output int n);
        for (int k = 0; k < 6; k++) s[k] = 0;
        s[1] = 1;
        n = 2;
        if (op == 6'h23) begin s[2] = 2; s[3] = 3; s[4] = 4; n = 5; end
        else if (op == 6'h2B) begin s[2] = 2; s[3] = 5; n = 4; end
        else if (op == 6'h00) begin s[2] = 6; s[3] = 7; n = 4; end
        else if (op == 6'h04) begin s[2] = 8; n = 3; end
        else if (op == 6'h08) begin s[2] = 9; s[3] = 10; n = 4; end
        else if (JEN && op == 6'h02) begin s[2] = 11; n = 3; end
    endtask

    task automatic chk_ctl(string nm, ctl_t exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: controls got %h want %h (state %0d)",
                     nm, act, exp, state_o);
        end
    endtask

    task automatic chk_st(string nm, int exp);
        checks++;
        if (state_o !== 4'(exp)) begin
            errs++;
            $display("FAIL %s: state_o got %0d want %0d", nm, state_o, exp);
        end
    endtask

    task automatic chk_cnt(string nm, logic [CW-1:0] exp);
        checks++;
        if (instr_count_o !== exp) begin
            errs++;
            $display("FAIL %s: instr_count_o got %0d want %0d",
                     nm, instr_count_o, exp);
        end
    endtask

    // Entered and left just after a rising edge with the FSM in FETCH.
    task automatic run_instr(logic [5:0] op, logic [5:0] fn, int abort, int steps);
        int s[6];
        int n;
        int st;
        ctl_t e;
        Op = op;
        Funct = fn;
        get_seq(op, s, n);
        if (steps <= 0) steps = n;
        for (int i = 0; i < steps; i++) begin
            if (i == abort) begin
                rst_n = 1'b0;
                @(negedge clk);
                chk_ctl("abort_ctl", gated(model(0, op, fn)));
                @(posedge clk);
                #1;
                exp_cnt = '0;
                chk_st("abort_state", 0);
                chk_cnt("abort_cnt", exp_cnt);
                rst_n = 1'b1;
                return;
            end
            st = (i < n) ? s[i] : 0;
            e = model(st, op, fn);
            @(negedge clk);
            chk_st("seq_state", st);
            chk_ctl("seq_ctl", e);
            chk_cnt("seq_cnt", exp_cnt);
            if (e.done) exp_cnt = exp_cnt + 1'b1;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset(int cyc);
        rst_n = 1'b0;
        for (int i = 0; i < cyc; i++) begin
            @(negedge clk);
            chk_ctl("rst_ctl", gated(model(0, Op, Funct)));
            if (i > 0) begin
                chk_st("rst_state", 0);
                chk_cnt("rst_cnt", '0);
            end
            @(posedge clk);
            #1;
        end
        exp_cnt = '0;
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [5:0] op;
        logic [5:0] fn;
        int         lat;
        string      nm;
    } vec_t;

    vec_t tbl[12];
    logic [CW-1:0] c0;
    logic [5:0] rop, rfn;
    int r;

    initial begin
        tbl[0]  = '{6'h23, 6'h00, 5, "lw"};
        tbl[1]  = '{6'h00, 6'h22, 4, "r_sub"};
        tbl[2]  = '{6'h00, 6'h2A, 4, "r_slt"};
        tbl[3]  = '{6'h04, 6'h00, 3, "beq"};
        tbl[4]  = '{6'h2B, 6'h00, 4, "sw"};
        tbl[5]  = '{6'h3F, 6'h00, 2, "illegal"};
        tbl[6]  = '{6'h02, 6'h00, JEN ? 3 : 2, "j"};
        tbl[7]  = '{6'h08, 6'h00, 4, "addi"};
        tbl[8]  = '{6'h00, 6'h20, 4, "r_add"};
        tbl[9]  = '{6'h00, 6'h24, 4, "r_and"};
        tbl[10] = '{6'h00, 6'h25, 4, "r_or"};
        tbl[11] = '{6'h00, 6'h3F, 4, "r_badfunct"};

        @(posedge clk);
        #1;
        do_reset(3);

        for (int t = 0; t < 12; t++) begin
            c0 = exp_cnt;
            run_instr(tbl[t].op, tbl[t].fn, -1, tbl[t].lat);
            chk_st({tbl[t].nm, "_end_state"}, 0);
            chk_cnt({tbl[t].nm, "_end_cnt"}, c0 + 1'b1);
        end

        run_instr(6'h23, 6'h00, 3, 0);
        run_instr(6'h08, 6'h00, -1, 0);

        do_reset(2);
        for (int k = 0; k < 255; k++) run_instr(6'h3F, 6'h00, -1, 0);
        chk_cnt("wrap_pre", {CW{1'b1}});
        run_instr(6'h08, 6'h00, -1, 0);
        chk_cnt("wrap_post", '0);

        for (int k = 0; k < 400; k++) begin
            r = $urandom_range(0, 9);
            case (r)
                0: rop = 6'h23;
                1: rop = 6'h2B;
                2, 3: rop = 6'h00;
                4: rop = 6'h04;
                5: rop = 6'h08;
                6: rop = 6'h02;
                default: rop = 6'($urandom);
            endcase
            case ($urandom_range(0, 6))
                0: rfn = 6'h20;
                1: rfn = 6'h22;
                2: rfn = 6'h24;
                3: rfn = 6'h25;
                4: rfn = 6'h2A;
                default: rfn = 6'($urandom);
            endcase
            run_instr(rop, rfn,
                      ($urandom_range(0, 19) == 0) ? $urandom_range(0, 4) : -1, 0);
        end

        @(negedge clk);
        chk_st("final_state", 0);
        chk_cnt("final_cnt", exp_cnt);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
